// File: rtl/regfile_scan_pkg.sv
// ---------------------------------------------------------------------------
// regfile_scan_pkg
// Shared constants and types for the regfile scan controller slice.
//   NUM_REGS       - registers streamed out after a run (indices 0..NUM_REGS-1)
//   REG_IDX_W      - width of a register index / regfile address
//   CYCLE_W        - width of the run-cycle counter and num_cycles input
//   DEFAULT_CYCLES - run length substituted when num_cycles is zero
//   scan_state_t   - controller states
// ---------------------------------------------------------------------------
package regfile_scan_pkg;

  localparam int NUM_REGS       = 32;
  localparam int REG_IDX_W      = 5;
  localparam int CYCLE_W        = 10;
  localparam int DEFAULT_CYCLES = 255;

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    ADDR,
    SCAN,
    DONE
  } scan_state_t;

endpackage

// File: rtl/regfile_scan_ctrl_if.sv
// ---------------------------------------------------------------------------
// regfile_scan_ctrl_if
// Valid/ready beat stream from the scan controller to the checker, plus the
// scan-complete flag.
//   scan_valid - beat valid (controller -> checker)
//   scan_ready - checker accepts beat (checker -> controller)
//   scan_reg   - register index of the current beat
//   scan_data  - register value of the current beat
//   done       - all registers have been streamed
// ---------------------------------------------------------------------------
interface regfile_scan_ctrl_if;
  import regfile_scan_pkg::*;

  logic                 scan_valid;
  logic                 scan_ready;
  logic [REG_IDX_W-1:0] scan_reg;
  logic [31:0]          scan_data;
  logic                 done;

  modport master (
    output scan_valid,
    output scan_reg,
    output scan_data,
    output done,
    input  scan_ready
  );

  modport slave (
    input  scan_valid,
    input  scan_reg,
    input  scan_data,
    input  done,
    output scan_ready
  );

endinterface

// File: rtl/regfile_scan_ctrl_run_cycle_counter.sv
// ---------------------------------------------------------------------------
// run_cycle_counter
// Counts processor run cycles against a latched limit.
//   clock    - system clock
//   reset    - asynchronous, active-low
//   load     - clear the count and latch a new limit (zero selects the default)
//   enable   - count this cycle
//   limit_in - requested run length
//   count    - cycles counted so far; saturates at the latched limit
//   terminal - this enabled cycle brings count up to the limit
// ---------------------------------------------------------------------------
module run_cycle_counter
  import regfile_scan_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic               load,
  input  logic               enable,
  input  logic [CYCLE_W-1:0] limit_in,
  output logic [CYCLE_W-1:0] count,
  output logic               terminal
);

  localparam logic [CYCLE_W-1:0] ONE         = CYCLE_W'(1);
  localparam logic [CYCLE_W-1:0] DEFAULT_LIM = CYCLE_W'(DEFAULT_CYCLES);

  logic [CYCLE_W-1:0] limit_q;
  logic               below_limit;

  assign below_limit = (count != limit_q);

  // The limit never exceeds the counter range, so holding at the limit is
  // all the overflow protection that is needed.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count   <= '0;
      limit_q <= '0;
    end else if (load) begin
      count   <= '0;
      limit_q <= (limit_in == '0) ? DEFAULT_LIM : limit_in;
    end else if (enable && below_limit) begin
      count <= count + ONE;
    end
  end

  // Terminal looks one increment ahead so the FSM can drop the run gate on
  // the same edge that the count reaches the limit.
  assign terminal = enable && below_limit && ((count + ONE) == limit_q);

endmodule

// File: rtl/regfile_scan_ctrl.sv
// ---------------------------------------------------------------------------
// regfile_scan_ctrl
// Runs the processor for a programmed number of cycles, freezes it, then
// takes over regfile read port A and streams every register to a checker.
//   clock       - system clock, rising edge
//   reset       - asynchronous, active-low
//   start       - begin a run (honoured only in IDLE or DONE)
//   num_cycles  - run length, latched on an accepted start (0 = default)
//   proc_rs1    - processor's read-port-A address
//   rf_rs1      - address driven to regfile read port A
//   rf_dataA    - regfile read port A data (combinational read)
//   proc_run    - processor clock-enable
//   cycle_count - cycles executed in the current/last run
//   scan        - beat stream to the checker (valid/ready, index, data, done)
// ---------------------------------------------------------------------------
module regfile_scan_ctrl
  import regfile_scan_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic [CYCLE_W-1:0]   num_cycles,
  input  logic [REG_IDX_W-1:0] proc_rs1,
  output logic [REG_IDX_W-1:0] rf_rs1,
  input  logic [31:0]          rf_dataA,
  output logic                 proc_run,
  output logic [CYCLE_W-1:0]   cycle_count,
  regfile_scan_ctrl_if.master  scan
);

  localparam logic [REG_IDX_W-1:0] LAST_IDX = REG_IDX_W'(NUM_REGS - 1);

  scan_state_t          state;
  scan_state_t          state_next;
  logic [REG_IDX_W-1:0] scan_idx;
  logic                 load_run;
  logic                 count_en;
  logic                 run_term;
  logic                 beat_accept;
  logic                 last_beat;

  run_cycle_counter u_run_cycle_counter (
    .clock    (clock),
    .reset    (reset),
    .load     (load_run),
    .enable   (count_en),
    .limit_in (num_cycles),
    .count    (cycle_count),
    .terminal (run_term)
  );

  assign beat_accept = scan.scan_valid && scan.scan_ready;
  assign last_beat   = (scan_idx == LAST_IDX);

  // The controller owns read port A only while scanning; the processor sees
  // its own address at all other times.
  assign rf_rs1 = (state == ADDR || state == SCAN) ? scan_idx : proc_rs1;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. Start is only looked at from IDLE and DONE, so pulses
  // during a run or scan are dropped on purpose.
  always_comb begin
    state_next = state;
    load_run   = 1'b0;
    count_en   = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          load_run   = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        count_en = 1'b1;
        if (run_term) begin
          state_next = ADDR;
        end
      end
      ADDR: begin
        state_next = SCAN;
      end
      SCAN: begin
        if (beat_accept) begin
          state_next = last_beat ? DONE : ADDR;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Scan datapath. ADDR gives the regfile a full cycle with the scan index
  // on its address before the beat is captured, which keeps rf_dataA off
  // the checker's timing path. The captured beat is frozen until accepted.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      proc_run       <= 1'b0;
      scan_idx       <= '0;
      scan.scan_valid <= 1'b0;
      scan.scan_reg  <= '0;
      scan.scan_data <= '0;
      scan.done      <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            proc_run  <= 1'b1;
            scan.done <= 1'b0;
          end
        end
        RUN: begin
          if (run_term) begin
            proc_run <= 1'b0;
            scan_idx <= '0;
          end
        end
        ADDR: begin
          scan.scan_data  <= rf_dataA;
          scan.scan_reg   <= scan_idx;
          scan.scan_valid <= 1'b1;
        end
        SCAN: begin
          if (beat_accept) begin
            scan.scan_valid <= 1'b0;
            if (last_beat) begin
              scan.done <= 1'b1;
            end else begin
              scan_idx <= scan_idx + REG_IDX_W'(1);
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
